// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, memory-wait holds
// with a timeout into a sticky error state, plus saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             id_valid,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StFlush   = 2'b01,
        StMemWait = 2'b10,
        StError   = 2'b11
    } state_e;

    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);
    localparam logic [8:0] TmoLimit  = 9'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic             ret_flush_q, ret_flush_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [8:0]       tmo_inc;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, flushc_q;

    logic load_use;
    logic front_hold, back_hold, flush, lu_bubble;

    assign load_use = id_valid & ex_valid & ex_memrd & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign tmo_inc  = {1'b0, tmo_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        ret_flush_d = ret_flush_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        front_hold  = 1'b0;
        back_hold   = 1'b0;
        flush       = 1'b0;
        lu_bubble   = 1'b0;
        unique case (state_q)
            StRun, StFlush: begin
                if (mem_busy) begin
                    front_hold  = 1'b1;
                    back_hold   = 1'b1;
                    ret_flush_d = (state_q == StFlush);
                    tmo_d       = 8'd1;
                    // A one-cycle timeout expires on the very first busy cycle.
                    if (TmoLimit <= 9'd1) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StMemWait;
                    end
                end else if (state_q == StFlush) begin
                    flush = 1'b1;
                    rem_d = rem_q - 3'd1;
                    if (rem_q <= 3'd1) begin
                        rem_d   = 3'd0;
                        state_d = StRun;
                    end
                end else if (ex_br_taken) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        rem_d   = FlushInit;
                    end
                end else if (load_use) begin
                    front_hold = 1'b1;
                    lu_bubble  = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_busy) begin
                    front_hold = 1'b1;
                    back_hold  = 1'b1;
                    tmo_d      = tmo_inc[7:0];
                    if (tmo_inc >= TmoLimit) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end
                end else begin
                    tmo_d   = 8'd0;
                    state_d = ret_flush_q ? StFlush : StRun;
                end
            end
            StError: begin
                front_hold = 1'b1;
                back_hold  = 1'b1;
                err_d      = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    // Control outputs are forced low while reset is asserted, whatever the inputs.
    assign pc_hold     = RST_n & front_hold;
    assign ifid_hold   = RST_n & front_hold;
    assign exmem_hold  = RST_n & back_hold;
    assign ifid_flush  = RST_n & flush;
    assign idex_bubble = RST_n & (flush | lu_bubble);
    assign state       = state_q;
    assign err         = err_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flushc_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= StRun;
            rem_q       <= 3'd0;
            ret_flush_q <= 1'b0;
            tmo_q       <= 8'd0;
            err_q       <= 1'b0;
            stall_q     <= '0;
            flushc_q    <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ret_flush_q <= ret_flush_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            if (pc_hold && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (ifid_flush && (flushc_q != '1)) begin
                flushc_q <= flushc_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: decode vector table, directed multi-cycle sequences and a random run
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned FC = 2;
    localparam int unsigned MT = 4;

    logic          CLK, RST_n;
    logic          id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_memrd, ex_br_taken, mem_busy;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          pc_hold, ifid_hold, exmem_hold, ifid_flush, idex_bubble, err;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CW), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .exmem_hold(exmem_hold),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .state(state), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       idv, u1, u2;
        logic [4:0] rs1, rs2;
        logic       exv, memrd;
        logic [4:0] rd;
        logic       br, busy;
    } in_t;

    // exp = {pc_hold, ifid_hold, exmem_hold, ifid_flush, idex_bubble}
    typedef struct {
        in_t        in;
        logic [4:0] exp;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Model: sticky error, inside a memory wait (with its consecutive busy count),
    // and number of flush cycles still owed.
    bit m_err, m_wait;
    int m_busy_run, m_flush_left, m_stall, m_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_err = 0; m_wait = 0; m_busy_run = 0; m_flush_left = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic logic [4:0] m_ctrl(input in_t v);
        logic lu;
        lu = v.idv && v.exv && v.memrd && (v.rd != 0) &&
             ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (m_err) return 5'b11100;
        if (m_wait) return v.busy ? 5'b11100 : 5'b00000;
        if (m_flush_left > 0) return v.busy ? 5'b11100 : 5'b00011;
        if (v.busy) return 5'b11100;
        if (v.br) return 5'b00011;
        if (lu) return 5'b11001;
        return 5'b00000;
    endfunction

    function automatic logic [1:0] m_state();
        if (m_err) return 2'd3;
        if (m_wait) return 2'd2;
        if (m_flush_left > 0) return 2'd1;
        return 2'd0;
    endfunction

    task automatic start_wait();
        m_busy_run = 1;
        if (m_busy_run >= MT) m_err = 1;
        else m_wait = 1;
    endtask

    task automatic m_update(input in_t v, input logic [4:0] c);
        if (c[4] && m_stall < (1 << CW) - 1) m_stall++;
        if (c[1] && m_flush < (1 << CW) - 1) m_flush++;
        if (m_err) begin
        end else if (m_wait) begin
            if (v.busy) begin
                m_busy_run++;
                if (m_busy_run >= MT) begin m_err = 1; m_wait = 0; end
            end else begin
                m_wait = 0; m_busy_run = 0;
            end
        end else if (m_flush_left > 0) begin
            if (v.busy) start_wait();
            else m_flush_left--;
        end else if (v.busy) begin
            start_wait();
        end else if (v.br) begin
            m_flush_left = FC - 1;
        end
    endtask

    task automatic drive(input in_t v);
        id_valid = v.idv; id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_rs1 = v.rs1; id_rs2 = v.rs2;
        ex_valid = v.exv; ex_memrd = v.memrd; ex_rd = v.rd; ex_br_taken = v.br; mem_busy = v.busy;
    endtask

    // Apply inputs just after a rising edge, compare at the falling edge, advance the model.
    task automatic step(input in_t v);
        logic [4:0] c;
        drive(v);
        @(negedge CLK);
        c = m_ctrl(v);
        check("ctrl", {27'd0, pc_hold, ifid_hold, exmem_hold, ifid_flush, idex_bubble}, {27'd0, c});
        check("state", {30'd0, state}, {30'd0, m_state()});
        check("err", {31'd0, err}, {31'd0, m_err});
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        @(posedge CLK);
        m_update(v, c);
        #1;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        drive('0);
        repeat (2) @(posedge CLK);
        #1;
        RST_n = 1'b1;
        m_reset();
    endtask

    function automatic in_t mk(input logic idv, u1, u2, input logic [4:0] rs1, rs2,
                               input logic exv, memrd, input logic [4:0] rd,
                               input logic br, busy);
        in_t v;
        v.idv = idv; v.u1 = u1; v.u2 = u2; v.rs1 = rs1; v.rs2 = rs2;
        v.exv = exv; v.memrd = memrd; v.rd = rd; v.br = br; v.busy = busy;
        return v;
    endfunction

    vec_t vecs[11];
    in_t  idle, lu5, brv, busyv;

    initial begin
        idle  = '0;
        lu5   = mk(1, 1, 0, 5, 0, 1, 1, 5, 0, 0);
        brv   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        busyv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[0]  = '{lu5,                                5'b11001};
        vecs[1]  = '{mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 0),   5'b00000};
        vecs[2]  = '{mk(1, 1, 0, 3, 7, 1, 1, 7, 0, 0),   5'b00000};
        vecs[3]  = '{mk(1, 0, 1, 9, 7, 1, 1, 7, 0, 0),   5'b11001};
        vecs[4]  = '{mk(1, 1, 0, 5, 0, 1, 0, 5, 0, 0),   5'b00000};
        vecs[5]  = '{mk(0, 1, 0, 5, 0, 1, 1, 5, 0, 0),   5'b00000};
        vecs[6]  = '{mk(1, 1, 0, 5, 0, 0, 1, 5, 0, 0),   5'b00000};
        vecs[7]  = '{brv,                                5'b00011};
        vecs[8]  = '{mk(1, 1, 0, 5, 0, 1, 1, 5, 1, 0),   5'b00011};
        vecs[9]  = '{mk(1, 1, 0, 5, 0, 1, 1, 5, 1, 1),   5'b11100};
        vecs[10] = '{idle,                               5'b00000};

        RST_n = 1'b0;
        drive('0);
        m_reset();
        #3;
        check("reset_outputs", {27'd0, pc_hold, ifid_hold, exmem_hold, ifid_flush, idex_bubble}, 0);
        check("reset_state", {29'd0, state, err}, 0);
        do_reset();

        // Single-cycle decode from RUN, then idle until the model is back in RUN.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].in);
            @(negedge CLK);
            check($sformatf("vec%0d", i),
                  {27'd0, pc_hold, ifid_hold, exmem_hold, ifid_flush, idex_bubble},
                  {27'd0, vecs[i].exp});
            @(posedge CLK);
            m_update(vecs[i].in, m_ctrl(vecs[i].in));
            #1;
            repeat (3) step(idle);
        end

        // Branch plus load-use: two flush cycles, no stall.
        do_reset();
        step(vecs[8].in);
        step(lu5);
        check("br_lu_flush_cnt", 32'(flush_cnt), 2);
        check("br_lu_stall_cnt", 32'(stall_cnt), 0);
        check("br_lu_state", 32'(state), 0);

        // Memory busy for 3 cycles while one flush cycle is still owed.
        do_reset();
        step(brv);
        check("flush_state", 32'(state), 1);
        repeat (3) step(busyv);
        check("wait_state", 32'(state), 2);
        check("wait_stall_cnt", 32'(stall_cnt), 3);
        step(idle);
        check("resume_flush", 32'(state), 1);
        step(idle);
        check("flush_done", 32'(state), 0);
        check("flush_total", 32'(flush_cnt), 2);

        // Timeout into sticky error, then asynchronous reset mid-cycle.
        do_reset();
        repeat (3) step(busyv);
        check("pre_timeout", 32'(state), 2);
        step(busyv);
        check("timeout_state", 32'(state), 3);
        check("timeout_err", 32'(err), 1);
        repeat (2) step(idle);
        #2;
        drive(vecs[9].in);
        RST_n = 1'b0;
        #1;
        check("async_state", {29'd0, state, err}, 0);
        check("async_cnts", {stall_cnt, flush_cnt}, 0);
        check("async_ctrl", {27'd0, pc_hold, ifid_hold, exmem_hold, ifid_flush, idex_bubble}, 0);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        m_reset();

        // Reset released mid-FLUSH resumes cleanly in RUN.
        step(brv);
        do_reset();
        step(idle);

        // Stall counter saturation.
        do_reset();
        repeat (20) step(lu5);
        check("stall_sat", 32'(stall_cnt), (1 << CW) - 1);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            in_t v;
            v = mk(1'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
            step(v);
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush and bubble are asserted per taken branch (range 1..7).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, maximum consecutive MEM_WAIT cycles before error (range 1..255).
REQ-004 SHALL provide CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL provide RST_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide id_valid, id_use_rs1, id_use_rs2  input  1 each  ID instruction valid; rs1/rs2 actually read.
REQ-007 SHALL provide id_rs1, id_rs2  input  5 each  ID source register numbers.
REQ-008 SHALL provide ex_valid, ex_memrd  input  1 each  EX instruction valid; EX instruction is a load.
REQ-009 SHALL provide ex_rd  input  5  EX destination register.
REQ-010 SHALL provide ex_br_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-011 SHALL provide mem_busy  input  1  data memory not ready this cycle.
REQ-012 SHALL provide pc_hold, ifid_hold, exmem_hold  output  1 each  hold PC, hold IF/ID, hold EX/MEM and later stages.
REQ-013 SHALL provide ifid_flush, idex_bubble  output  1 each  squash IF/ID; insert NOP into ID/EX.
REQ-014 SHALL provide state  output  2  RUN=00, FLUSH=01, MEM_WAIT=10, ERROR=11.
REQ-015 SHALL provide err  output  1  sticky memory-timeout flag.
REQ-016 SHALL provide stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-017 Control outputs SHALL be combinational from the current state and inputs; state, counters and err SHALL be registered.
REQ-018 load_use SHALL be id_valid & ex_valid & ex_memrd & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 Priority in RUN SHALL be: mem_busy > ex_br_taken > load_use.
REQ-020 RUN with mem_busy: pc_hold=ifid_hold=exmem_hold=1 that cycle; next state MEM_WAIT; return target RUN; timeout counter loaded to 1.
REQ-021 RUN with ex_br_taken, no mem_busy: ifid_flush=idex_bubble=1 that cycle; if FLUSH_CYCLES>1, next state FLUSH with remaining count FLUSH_CYCLES-1; else stay RUN.
REQ-022 RUN with load_use only: pc_hold=ifid_hold=idex_bubble=1 for exactly that cycle; stay RUN (the bubble clears ex_valid, so the hazard does not re-fire).
REQ-023 FLUSH SHALL assert ifid_flush=idex_bubble=1, ignore load_use and ex_br_taken, decrement the remaining count, and return to RUN when it reaches 0.
REQ-024 FLUSH with mem_busy: all three holds=1, flush/bubble=0, remaining count frozen; next MEM_WAIT with return target FLUSH.
REQ-025 MEM_WAIT SHALL assert all three holds while mem_busy=1 and increment the timeout counter; first cycle with mem_busy=0 SHALL drive no holds and transition to the return target.
REQ-026 If the timeout counter reaches MEM_TIMEOUT with mem_busy still 1, the next state SHALL be ERROR and err SHALL be set.
REQ-027 ERROR SHALL assert all three holds and hold err=1 permanently until reset.
REQ-028 stall_cnt SHALL increment on every cycle with pc_hold=1; flush_cnt SHALL increment on every cycle with ifid_flush=1; both SHALL saturate at all-ones.

Reset
REQ-029 RST_n=0 SHALL immediately force state=RUN, err=0, counters=0, internal counts=0, and all control outputs 0 regardless of inputs.
REQ-030 Reset deassertion mid-FLUSH or mid-MEM_WAIT SHALL resume in RUN with no residual flush or hold.

Verification
REQ-031 Load-use: ex_memrd=1, ex_rd=5, id_rs1=5, id_use_rs1=1, all valid -> one cycle pc_hold=ifid_hold=idex_bubble=1, stall_cnt=1.
REQ-032 x0 and unused operand: ex_rd=0=id_rs1, then id_rs2=ex_rd=7 with id_use_rs2=0 -> no hold, no bubble.
REQ-033 Branch with load_use in the same cycle, FLUSH_CYCLES=2 -> flush+bubble for 2 cycles, no pc_hold, flush_cnt=2.
REQ-034 mem_busy high 3 cycles during FLUSH remaining=1 -> 3 hold cycles, then 1 flush cycle, then RUN; stall_cnt=3.
REQ-035 MEM_TIMEOUT=4, mem_busy held high -> state=ERROR, err=1 after 4 busy cycles; RST_n low mid-cycle clears everything asynchronously.
